// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ requesters.
// Optional transaction timeout enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk_400,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 arb_busy,
    output logic                 m_start_txn,
    output logic                 m_rw,
    output logic [6:0]           m_sub_addr,
    output logic [7:0]           m_data_in,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_data_ready,
    input  logic [7:0]           m_data_out
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("i2c_txn_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                cmd_rw_q, cmd_rw_d;
    logic [6:0]          cmd_addr_q, cmd_addr_d;
    logic [7:0]          cmd_wdata_q, cmd_wdata_d;
    logic [7:0]          rdata_q, rdata_d;

    logic [IdxW-1:0]     hi_idx, lo_idx, pick_idx;
    logic                hi_valid;
    logic                sel_rw;
    logic [6:0]          sel_addr;
    logic [7:0]          sel_wdata;
    logic                timeout;
    logic                err;

    // Lowest set bit at or above rr_ptr wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IdxW'(i);
            end
            if (req[i] && (i >= int'(rr_ptr_q))) begin
                hi_idx   = IdxW'(i);
                hi_valid = 1'b1;
            end
        end
        pick_idx = hi_valid ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IdxW'(i) == pick_idx) begin
                sel_rw    = req_rw[i];
                sel_addr  = req_addr[7*i +: 7];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            waiting;

    assign waiting = (state_q == StWaitBusy) || (state_q == StWaitDone);
    assign timeout = waiting && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
        if (state_q == StIdle) begin
            err_d = 1'b0;
        end else if (timeout && !(state_q == StWaitDone && m_done)) begin
            // A done arriving on the final cycle still counts as a clean completion.
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_400 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        gnt_d       = gnt_q;
        cmd_rw_d    = cmd_rw_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    idx_d       = pick_idx;
                    gnt_d       = NUM_REQ'(1) << pick_idx;
                    cmd_rw_d    = sel_rw;
                    cmd_addr_d  = sel_addr;
                    cmd_wdata_d = sel_wdata;
                    rdata_d     = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (timeout) begin
                    state_d = StResp;
                end else if (m_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (m_data_ready) begin
                    rdata_d = m_data_out;
                end
                if (m_done || timeout) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                gnt_d    = '0;
                rr_ptr_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_400 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            gnt_q       <= '0;
            cmd_rw_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            gnt_q       <= gnt_d;
            cmd_rw_q    <= cmd_rw_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // All outputs decode from registered state so an async reset clears them at once.
    assign arb_busy    = (state_q != StIdle);
    assign m_start_txn = (state_q == StIssue);
    assign gnt         = gnt_q;
    assign m_rw        = arb_busy & cmd_rw_q;
    assign m_sub_addr  = arb_busy ? cmd_addr_q : '0;
    assign m_data_in   = arb_busy ? cmd_wdata_q : '0;
    assign rsp_valid   = (state_q == StResp) ? gnt_q : '0;
    assign rsp_rdata   = ((state_q == StResp) && cmd_rw_q && !err) ? rdata_q : '0;
    assign rsp_err     = (state_q == StResp) && err;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomized self-checking bench for i2c_txn_arbiter against a queue-free
// transaction-level model (pointer + per-requester command table).
module tb_i2c_txn_arbiter;

    localparam int NREQ = 3;
    localparam int TO   = 64;

    logic              clk_400 = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_rw;
    logic [7*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic              arb_busy;
    logic              m_start_txn;
    logic              m_rw;
    logic [6:0]        m_sub_addr;
    logic [7:0]        m_data_in;
    logic              m_busy;
    logic              m_done;
    logic              m_data_ready;
    logic [7:0]        m_data_out;

    i2c_txn_arbiter #(
        .NUM_REQ       (NREQ),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_400     (clk_400),
        .rst_n       (rst_n),
        .req         (req),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .arb_busy    (arb_busy),
        .m_start_txn (m_start_txn),
        .m_rw        (m_rw),
        .m_sub_addr  (m_sub_addr),
        .m_data_in   (m_data_in),
        .m_busy      (m_busy),
        .m_done      (m_done),
        .m_data_ready(m_data_ready),
        .m_data_out  (m_data_out)
    );

    always #5 clk_400 = ~clk_400;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    int         rr_m;
    logic       rw_m   [NREQ];
    logic [6:0] addr_m [NREQ];
    logic [7:0] wd_m   [NREQ];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_cmd(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
        rw_m[i]   = rw;
        addr_m[i] = a;
        wd_m[i]   = d;
        req_rw[i]            = rw;
        req_addr[7*i +: 7]   = a;
        req_wdata[8*i +: 8]  = d;
    endtask

    // Called at posedge+1 of an IDLE cycle with req nonzero; returns at posedge+1 of the next IDLE.
    task automatic do_txn(input int bdly, input int ddly, input int rdy_at, input logic [7:0] rbyte,
                          input bit drop, input bit keep, output int got);
        int              ei;
        int              n;
        bit              found;
        bit              ok;
        logic [NREQ-1:0] eg;
        logic [7:0]      er;
        got = -1;
        ei  = model_pick(req, rr_m);
        if (ei < 0) return;
        eg     = '0;
        eg[ei] = 1'b1;
        @(negedge clk_400);
        check_eq("idle", {28'd0, arb_busy, m_start_txn, |gnt, |rsp_valid}, 32'd0);
        found = 0;
        n     = 0;
        while (n < 4 && !found) begin
            @(negedge clk_400);
            if (m_start_txn) found = 1;
            else n++;
        end
        check_eq("start_seen", {31'd0, found}, 32'd1);
        if (!found) return;
        check_eq("start_lat", n, 0);
        got = onehot_idx(gnt);
        check_eq("gnt", gnt, eg);
        check_eq("m_sub_addr", m_sub_addr, addr_m[ei]);
        check_eq("m_rw", m_rw, rw_m[ei]);
        check_eq("m_data_in", m_data_in, wd_m[ei]);
        ok = 1;
        for (int c = 0; c < bdly + ddly + 2; c++) begin
            @(posedge clk_400);
            #1;
            m_busy       = 1'b0;
            m_done       = 1'b0;
            m_data_ready = 1'b0;
            if (c < bdly) begin
                if (c == 0) begin
                    // Stray done/data while the master is not yet busy must be ignored.
                    m_done       = 1'b1;
                    m_data_ready = 1'b1;
                    m_data_out   = 8'hEE;
                end
            end else if (c == bdly) begin
                m_busy = 1'b1;
            end else begin
                m_busy       = 1'b1;
                m_data_out   = rbyte;
                m_data_ready = ((c - bdly - 1) == rdy_at);
                m_done       = ((c - bdly - 1) == ddly);
                if (drop && (c - bdly - 1) == 0) req[ei] = 1'b0;
            end
            @(negedge clk_400);
            if (m_start_txn || rsp_valid != '0 || gnt != eg || m_sub_addr != addr_m[ei] ||
                m_rw != rw_m[ei] || m_data_in != wd_m[ei] || !arb_busy) ok = 0;
        end
        check_eq("hold", {31'd0, ok}, 32'd1);
        @(posedge clk_400);
        #1;
        m_busy       = 1'b0;
        m_done       = 1'b0;
        m_data_ready = 1'b0;
        m_data_out   = 8'($urandom);
        @(negedge clk_400);
        er = (rw_m[ei] && rdy_at >= 0) ? rbyte : 8'h00;
        check_eq("rsp_valid", rsp_valid, eg);
        check_eq("rsp_rdata", rsp_rdata, er);
        check_eq("rsp_err", rsp_err, 0);
        rr_m = (ei + 1) % NREQ;
        @(posedge clk_400);
        #1;
        if (!keep) req[ei] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         got;
        int         n;
        bit         seen;
        bit         found;
        int         bd;
        int         dd;
        int         ra;
        logic [7:0] rb;

        rst_n        = 1'b0;
        req          = '0;
        req_rw       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        m_busy       = 1'b0;
        m_done       = 1'b0;
        m_data_ready = 1'b0;
        m_data_out   = '0;
        rr_m         = 0;
        for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, 7'h00, 8'h00);
        repeat (3) @(negedge clk_400);
        check_eq("reset_outs", {gnt, rsp_valid, rsp_rdata, rsp_err, arb_busy, m_start_txn, m_rw,
                                m_sub_addr, m_data_in}, 0);
        @(posedge clk_400);
        #1;
        rst_n = 1'b1;

        // Single write.
        set_cmd(0, 1'b0, 7'h01, 8'hA5);
        req[0] = 1'b1;
        do_txn(3, 36, -1, 8'h00, 0, 0, got);

        // Read capture, read with data on the done cycle, read without data.
        set_cmd(1, 1'b1, 7'h03, 8'h11);
        req[1] = 1'b1;
        do_txn(1, 5, 2, 8'h3C, 0, 0, got);
        set_cmd(2, 1'b1, 7'h55, 8'h22);
        req[2] = 1'b1;
        do_txn(2, 3, 3, 8'h5A, 0, 0, got);
        set_cmd(0, 1'b1, 7'h7F, 8'h33);
        req[0] = 1'b1;
        do_txn(2, 4, -1, 8'h99, 0, 0, got);

        // Reset while waiting for done; pointer is nonzero beforehand.
        set_cmd(1, 1'b0, 7'h12, 8'h34);
        req = 3'b010;
        @(negedge clk_400);
        @(negedge clk_400);
        check_eq("rst_pre_start", m_start_txn, 1);
        @(posedge clk_400);
        #1 m_busy = 1'b1;
        @(posedge clk_400);
        #1;
        @(posedge clk_400);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", {gnt, arb_busy, m_start_txn, rsp_valid, m_sub_addr}, 0);
        m_busy = 1'b0;
        seen   = 0;
        repeat (2) begin
            @(negedge clk_400);
            if (rsp_valid != '0) seen = 1;
        end
        check_eq("rst_no_rsp", {31'd0, seen}, 0);
        @(posedge clk_400);
        #1;
        rst_n = 1'b1;
        rr_m  = 0;

        // All requests held: grants rotate 0,1,2,0,1.
        req = '1;
        for (int k = 0; k < 5; k++) begin
            do_txn(1, 2 + k, -1, 8'h00, 0, 1, got);
            check_eq("rr_order", got, k % NREQ);
        end

        // Request dropped mid-transaction still completes, with no restart.
        req = 3'b001;
        do_txn(1, 4, -1, 8'h00, 1, 0, got);
        seen = 0;
        repeat (4) begin
            @(negedge clk_400);
            if (m_start_txn || arb_busy) seen = 1;
        end
        check_eq("drop_no_restart", {31'd0, seen}, 0);
        @(posedge clk_400);
        #1;

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && ($urandom_range(0, 1) == 1 || (req == '0 && i == NREQ - 1))) begin
                    set_cmd(i, 1'($urandom), 7'($urandom), 8'($urandom));
                    req[i] = 1'b1;
                end
            end
            bd = $urandom_range(1, 4);
            dd = $urandom_range(0, 12);
            ra = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, dd);
            rb = 8'($urandom);
            do_txn(bd, dd, ra, rb, $urandom_range(0, 3) == 0, 0, got);
        end

`ifdef I2C_ARB_TIMEOUT_EN
        // Master never responds: response with error after the timeout window.
        req = 3'b100;
        found = 0;
        n = 0;
        while (n < 4 && !found) begin
            @(negedge clk_400);
            if (m_start_txn) found = 1;
            n++;
        end
        check_eq("to_start", {31'd0, found}, 1);
        n    = 0;
        seen = 0;
        while (n < 3 * TO && !seen) begin
            @(negedge clk_400);
            n++;
            if (rsp_valid != '0) seen = 1;
        end
        check_eq("to_lat", {31'd0, (n == TO || n == TO + 1)}, 1);
        check_eq("to_rsp", rsp_valid, 3'b100);
        check_eq("to_err", rsp_err, 1);
        check_eq("to_rdata", rsp_rdata, 0);
        rr_m = 0;
        @(posedge clk_400);
        #1 req = '0;
        @(negedge clk_400);
        check_eq("to_idle", arb_busy, 0);
`endif

        req = '0;
        repeat (2) @(negedge clk_400);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
